// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute and drives datapath enables and selects.
module mips_multicycle_ctrl #(
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic       zero_ext,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_t     cur;
  state_t     nxt;
  logic [5:0] op_q;

  assign state = cur;

  // State register; opcode latched while decoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= S_FETCH;
      op_q <= 6'd0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) op_q <= opcode;
    end
  end

  // Next-state and output decode.
  always_comb begin
    nxt           = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    zero_ext      = 1'b0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    illegal_op    = 1'b0;
    halted        = 1'b0;
    unique case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OP_R:                   nxt = S_R_EXEC;
          OP_LW, OP_SW:           nxt = S_MEM_ADDR;
          OP_BEQ:                 nxt = S_BRANCH;
          OP_J:                   nxt = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            nxt = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        nxt      = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        nxt       = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_I_WB;
        if (op_q == OP_ANDI) begin
          alu_op   = 3'b011;
          zero_ext = 1'b1;
        end else if (op_q == OP_ORI) begin
          alu_op   = 3'b100;
          zero_ext = 1'b1;
        end
      end
      S_I_WB: begin
        reg_write = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        nxt    = S_HALT;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule
